// File: rtl/mdu_stall_source.sv
// E-stage multiply/divide unit with HI/LO registers and the MDU stall source.
// Multi-cycle mult/div operations hold BUSY for a fixed latency; the
// result is committed to {HI,LO} only on the final BUSY cycle.
// Optional feature macro: MDU_MADD_EN enables madd/maddu (ops 110/111);
// when undefined those op codes are no-ops.
module mdu_stall_source #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MDU_Start,
  input  logic [2:0]  MDU_Op,
  input  logic [31:0] MDU_A,
  input  logic [31:0] MDU_B,
  input  logic        MDU_D,
  output logic        BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MDU_STALL
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [63:0]       result_q;
  logic              commit_q;

  logic              op_unsigned;
  logic [63:0]       mul_a, mul_b, product;
  logic              a_neg, b_neg, div_by_zero;
  logic [31:0]       div_n, div_d, div_d_safe;
  logic [31:0]       quot_mag, rem_mag, quot, rem;
  logic              long_op, commit_d;
  logic [63:0]       result_d;
  logic [CNT_W-1:0]  cycles_d;

  assign BUSY      = (state_q == S_RUN);
  assign MDU_STALL = MDU_D & (MDU_Start | BUSY);

  // Operand decode and single-cycle result computation for the op presented in E.
  // Signed division runs on magnitudes so that 0x80000000 / -1 yields
  // 0x80000000 rem 0 without relying on signed-overflow behaviour.
  always_comb begin
    op_unsigned = MDU_Op[0];
    mul_a       = op_unsigned ? {32'h0, MDU_A} : {{32{MDU_A[31]}}, MDU_A};
    mul_b       = op_unsigned ? {32'h0, MDU_B} : {{32{MDU_B[31]}}, MDU_B};
    product     = mul_a * mul_b;
    a_neg       = !op_unsigned && MDU_A[31];
    b_neg       = !op_unsigned && MDU_B[31];
    div_n       = a_neg ? -MDU_A : MDU_A;
    div_d       = b_neg ? -MDU_B : MDU_B;
    div_by_zero = (MDU_B == '0);
    div_d_safe  = div_by_zero ? 32'd1 : div_d;
    quot_mag    = div_n / div_d_safe;
    rem_mag     = div_n % div_d_safe;
    quot        = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
    rem         = a_neg ? -rem_mag : rem_mag;

    long_op  = 1'b0;
    commit_d = 1'b0;
    result_d = '0;
    cycles_d = '0;
    case (MDU_Op)
      3'b000, 3'b001: begin
        long_op  = 1'b1;
        commit_d = 1'b1;
        result_d = product;
        cycles_d = MULT_LOAD;
      end
      3'b010, 3'b011: begin
        long_op  = 1'b1;
        commit_d = !div_by_zero;
        result_d = {rem, quot};
        cycles_d = DIV_LOAD;
      end
`ifdef MDU_MADD_EN
      3'b110, 3'b111: begin
        long_op  = 1'b1;
        commit_d = 1'b1;
        result_d = {HI, LO} + product;
        cycles_d = MULT_LOAD;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic: IDLE -> RUN on a multi-cycle start, RUN -> IDLE on the last count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (MDU_Start && long_op) state_d = S_RUN;
      S_RUN:  if (cnt_q == CNT_W'(1))    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Latch result/latency at start, count down in RUN, commit HI/LO on the final cycle;
  // starts seen while RUN are ignored entirely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      result_q <= '0;
      commit_q <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else if (state_q == S_IDLE) begin
      if (MDU_Start) begin
        if (long_op) begin
          result_q <= result_d;
          commit_q <= commit_d;
          cnt_q    <= cycles_d;
        end else if (MDU_Op == 3'b100) begin
          HI <= MDU_A;
        end else if (MDU_Op == 3'b101) begin
          LO <= MDU_A;
        end
      end
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && commit_q) begin
        HI <= result_q[63:32];
        LO <= result_q[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mdu_stall_source.sv
// Scoreboard bench for mdu_stall_source: stimulus pushes the expected
// {HI,LO} and BUSY length per multi-cycle op, the monitor pops and compares
// whenever BUSY falls. Honours MDU_MADD_EN like the design.
module tb_mdu_stall_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MDU_Start;
  logic [2:0]  MDU_Op;
  logic [31:0] MDU_A, MDU_B;
  logic        MDU_D;
  logic        BUSY;
  logic [31:0] HI, LO;
  logic        MDU_STALL;

  always #5 clk = ~clk;

  mdu_stall_source #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .MDU_Start(MDU_Start), .MDU_Op(MDU_Op),
    .MDU_A(MDU_A), .MDU_B(MDU_B), .MDU_D(MDU_D), .BUSY(BUSY),
    .HI(HI), .LO(LO), .MDU_STALL(MDU_STALL)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned len;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: measure BUSY length and compare HI/LO once an operation completes.
  int unsigned busy_len = 0;
  logic        was_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy_len = 0;
      was_busy = 1'b0;
    end else if (BUSY) begin
      busy_len++;
      was_busy = 1'b1;
    end else if (was_busy) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, HI, e.hi);
        check({e.name, "_lo"}, LO, e.lo);
        check({e.name, "_len"}, busy_len, e.len);
      end
      busy_len = 0;
      was_busy = 1'b0;
    end
  end

  // Multi-cycle op with MDU_D=1; optionally injects an mtlo while BUSY.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int unsigned len, input bit inject);
    int unsigned n = 0;
    int unsigned stall_bad = 0;
    bit done = 0;
    exp_t e;
    e.name = name; e.hi = ehi; e.lo = elo; e.len = len;
    @(posedge clk); #1;
    sb.push_back(e);
    MDU_Start = 1'b1; MDU_Op = op; MDU_A = a; MDU_B = b; MDU_D = 1'b1;
    @(negedge clk);
    check({name, "_stall_start"}, 32'(MDU_STALL), 32'd1);
    @(posedge clk); #1;
    MDU_Start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      MDU_Start = 1'b0;
      if (BUSY) begin
        n++;
        if (MDU_STALL !== 1'b1) stall_bad++;
        if (inject && n == 2) begin
          MDU_Start = 1'b1; MDU_Op = 3'b101; MDU_A = 32'h0000_1234;
        end
      end else begin
        done = 1;
      end
    end
    if (!done) check({name, "_timeout"}, 32'd1, 32'd0);
    check({name, "_stall_busy"}, stall_bad, 32'd0);
    check({name, "_stall_after"}, 32'(MDU_STALL), 32'd0);
  endtask

  // Op that must complete without BUSY (mthi/mtlo, disabled madd).
  task automatic idle_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int unsigned busy_seen = 0;
    @(posedge clk); #1;
    MDU_Start = 1'b1; MDU_Op = op; MDU_A = a; MDU_B = b; MDU_D = 1'b1;
    @(negedge clk);
    check({name, "_stall_start"}, 32'(MDU_STALL), 32'd1);
    @(posedge clk); #1;
    MDU_Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (BUSY !== 1'b0) busy_seen++;
    end
    check({name, "_no_busy"}, busy_seen, 32'd0);
    check({name, "_hi"}, HI, ehi);
    check({name, "_lo"}, LO, elo);
  endtask

  initial begin
    reset_n = 1'b0; MDU_Start = 1'b0; MDU_Op = '0; MDU_A = '0; MDU_B = '0; MDU_D = 1'b1;
    #3;
    check("reset_busy",  32'(BUSY), 32'd0);
    check("reset_hi",    HI, 32'd0);
    check("reset_lo",    LO, 32'd0);
    check("reset_stall", 32'(MDU_STALL), 32'd0);
    #19 reset_n = 1'b1;

    run_op("mult",        3'b000, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 5,  0);
    run_op("multu",       3'b001, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5,  0);
    run_op("div",         3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    run_op("divu_by0",    3'b011, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    run_op("div_ovf",     3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 0);
    run_op("divu",        3'b011, 32'd100,       32'd7,        32'd2,         32'd14,        10, 0);
    run_op("div_neg_d",   3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10, 0);
    run_op("mult_inject", 3'b000, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5,  1);

    idle_op("mtlo",  3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
    idle_op("mthi",  3'b100, 32'h0000_0000, 32'd0, 32'h0000_0000, 32'h0000_1234);
    idle_op("mtlo2", 3'b101, 32'hFFFF_FFFF, 32'd0, 32'h0000_0000, 32'hFFFF_FFFF);

`ifdef MDU_MADD_EN
    run_op("maddu", 3'b111, 32'd1,         32'd1, 32'h0000_0001, 32'h0000_0000, 5, 0);
    run_op("madd",  3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF, 5, 0);
`else
    idle_op("maddu_off", 3'b111, 32'd1, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF);
`endif

    // Asynchronous abort mid-division: outputs clear without a clock edge.
    @(posedge clk); #1;
    MDU_Start = 1'b1; MDU_Op = 3'b010; MDU_A = 32'd100; MDU_B = 32'd3;
    @(posedge clk); #1;
    MDU_Start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", 32'(BUSY), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_hi",   HI, 32'd0);
    check("abort_lo",   LO, 32'd0);
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_stays_idle", 32'(BUSY), 32'd0);
    check("abort_hi_after",   HI, 32'd0);
    check("abort_lo_after",   LO, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
